axi_lite_reg_slave: RTL and testbench

AXI4-Lite responder that terminates an AXI_LITE Slave modport with a bank of NumRegs memory-mapped registers.
- Accepts AW and W independently and in any order, then issues one B response.
- Serves AR with one R response.
- Exposes register contents and per-register write pulses to hardware.
- Read-only registers are loaded from hardware.
- Sits at the leaf of the peripheral crossbar, as the counterpart to AXI_LITE masters.

---
 rtl/axi_pkg.sv | 12 +
 rtl/axi_lite_if.sv | 46 ++++
 rtl/axi_lite_reg_slave.sv | 160 ++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions: response and protection encodings.
package axi_pkg;

  typedef logic [1:0] resp_t;
  typedef logic [2:0] prot_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle with master and slave views.
interface AXI_LITE #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
);
  import axi_pkg::*;

  localparam int unsigned StrbW = AXI_DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  prot_t                     aw_prot;
  logic                      aw_valid;
  logic                      aw_ready;
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [StrbW-1:0]          w_strb;
  logic                      w_valid;
  logic                      w_ready;
  resp_t                     b_resp;
  logic                      b_valid;
  logic                      b_ready;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  prot_t                     ar_prot;
  logic                      ar_valid;
  logic                      ar_ready;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  resp_t                     r_resp;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport Slave (
    input aw_addr, aw_prot, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );

endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: buffered AW/W with one B per write, AR served with one R,
// read-only registers loadable from hardware.
module axi_lite_reg_slave
  import axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned NumRegs        = 16,
  parameter logic [NumRegs-1:0][AXI_DATA_WIDTH-1:0] RegRstVal = '0,
  parameter logic [NumRegs-1:0] ReadOnly = '0
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  AXI_LITE.Slave                                   slv,
  output logic [NumRegs-1:0][AXI_DATA_WIDTH-1:0]   reg_q_o,
  output logic [NumRegs-1:0]                       wr_pulse_o,
  input  logic [NumRegs-1:0]                       hw_load_i,
  input  logic [NumRegs-1:0][AXI_DATA_WIDTH-1:0]   hw_d_i
);

  localparam int unsigned StrbW   = AXI_DATA_WIDTH / 8;
  localparam int unsigned AddrLsb = $clog2(StrbW);

  typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
  typedef logic [AXI_DATA_WIDTH-1:0] data_t;
  typedef logic [StrbW-1:0]          strb_t;

  logic  aw_full_q, aw_full_d, w_full_q, w_full_d;
  addr_t aw_addr_q, aw_addr_d;
  data_t w_data_q, w_data_d;
  strb_t w_strb_q, w_strb_d;
  logic  b_valid_q, b_valid_d, r_valid_q, r_valid_d;
  resp_t b_resp_q, b_resp_d, r_resp_q, r_resp_d;
  data_t r_data_q, r_data_d;
  logic [NumRegs-1:0][AXI_DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NumRegs-1:0] wr_pulse_q, wr_pulse_d;

  logic  aw_hs, w_hs, ar_hs, commit;
  addr_t aw_idx, ar_idx;
  logic  unused_prot;

  assign slv.aw_ready = !aw_full_q && !b_valid_q;
  assign slv.w_ready  = !w_full_q && !b_valid_q;
  assign slv.ar_ready = !r_valid_q;
  assign slv.b_valid  = b_valid_q;
  assign slv.b_resp   = b_resp_q;
  assign slv.r_valid  = r_valid_q;
  assign slv.r_data   = r_data_q;
  assign slv.r_resp   = r_resp_q;
  assign reg_q_o      = regs_q;
  assign wr_pulse_o   = wr_pulse_q;
  assign unused_prot  = ^{slv.aw_prot, slv.ar_prot};

  assign aw_hs  = slv.aw_valid && slv.aw_ready;
  assign w_hs   = slv.w_valid && slv.w_ready;
  assign ar_hs  = slv.ar_valid && slv.ar_ready;
  assign commit = aw_full_q && w_full_q && !b_valid_q;
  assign aw_idx = aw_addr_q >> AddrLsb;
  assign ar_idx = slv.ar_addr >> AddrLsb;

  // Write channel buffers, B response and register array update.
  always_comb begin
    aw_full_d  = aw_full_q;
    aw_addr_d  = aw_addr_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = slv.aw_addr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = slv.w_data;
      w_strb_d = slv.w_strb;
    end
    if (b_valid_q && slv.b_ready) begin
      b_valid_d = 1'b0;
    end
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      b_valid_d = 1'b1;
      b_resp_d  = RESP_DECERR;
      for (int unsigned i = 0; i < NumRegs; i++) begin
        if (aw_idx == addr_t'(i)) begin
          if (ReadOnly[i]) begin
            b_resp_d = RESP_SLVERR;
          end else begin
            b_resp_d      = RESP_OKAY;
            wr_pulse_d[i] = 1'b1;
            for (int unsigned b = 0; b < StrbW; b++) begin
              if (w_strb_q[b]) regs_d[i][8*b +: 8] = w_data_q[8*b +: 8];
            end
          end
        end
      end
    end
    // Hardware loads only reach read-only registers, so they never collide with AXI writes.
    for (int unsigned i = 0; i < NumRegs; i++) begin
      if (ReadOnly[i] && hw_load_i[i]) regs_d[i] = hw_d_i[i];
    end
  end

  // Read channel: data sampled from the pre-edge register contents.
  always_comb begin
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    if (r_valid_q && slv.r_ready) begin
      r_valid_d = 1'b0;
    end
    if (ar_hs) begin
      r_valid_d = 1'b1;
      r_data_d  = '0;
      r_resp_d  = RESP_DECERR;
      for (int unsigned i = 0; i < NumRegs; i++) begin
        if (ar_idx == addr_t'(i)) begin
          r_data_d = regs_q[i];
          r_resp_d = RESP_OKAY;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
      regs_q     <= RegRstVal;
      wr_pulse_q <= '0;
    end else begin
      aw_full_q  <= aw_full_d;
      aw_addr_q  <= aw_addr_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: directed scenarios plus random traffic
// checked against an array model of the register map.
module tb_axi_lite_reg_slave;
  import axi_pkg::*;

  localparam int unsigned NRegs = 16;
  localparam logic [NRegs-1:0][31:0] RstVal =
    {{10{32'h0}}, 32'h1234_5678, {2{32'h0}}, 32'hAAAA_AAAA, {2{32'h0}}};
  localparam logic [NRegs-1:0] RoMask = 16'h0008;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  AXI_LITE #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) slv ();
  logic [NRegs-1:0][31:0] reg_q, hw_d;
  logic [NRegs-1:0]       wr_pulse, hw_load;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [NRegs];

  axi_lite_reg_slave #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .NumRegs(NRegs),
    .RegRstVal(RstVal), .ReadOnly(RoMask)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .slv(slv), .reg_q_o(reg_q),
    .wr_pulse_o(wr_pulse), .hw_load_i(hw_load), .hw_d_i(hw_d)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] rst_value(int i);
    case (i)
      2:       return 32'hAAAA_AAAA;
      5:       return 32'h1234_5678;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_ro(int i);
    return i == 3;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic logic [1:0] exp_wresp(logic [31:0] a);
    int idx = int'(a / 4);
    if (idx >= NRegs) return 2'b11;
    if (is_ro(idx)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NRegs; i++) model[i] = rst_value(i);
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    slv.aw_valid = 0; slv.aw_addr = '0; slv.aw_prot = '0;
    slv.w_valid = 0;  slv.w_data = '0;  slv.w_strb = '0;
    slv.b_ready = 0;
    slv.ar_valid = 0; slv.ar_addr = '0; slv.ar_prot = '0;
    slv.r_ready = 0;
    hw_load = '0; hw_d = '0;
  endtask

  task automatic timeout_fail(input string what);
    n_cmp++; n_bad++;
    $display("FAIL timeout_%s: waited 20 cycles, required handshake before that", what);
  endtask

  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    logic aw_pend = 1'b1, w_pend = 1'b1, aw_hs, w_hs;
    slv.aw_addr = a; slv.aw_prot = 3'($urandom); slv.aw_valid = 1;
    slv.w_data = d;  slv.w_strb = s;             slv.w_valid = 1;
    while ((aw_pend || w_pend) && n < 20) begin
      aw_hs = slv.aw_valid && slv.aw_ready;
      w_hs  = slv.w_valid && slv.w_ready;
      tick(); n++;
      if (aw_hs) begin aw_pend = 0; slv.aw_valid = 0; end
      if (w_hs)  begin w_pend = 0;  slv.w_valid = 0;  end
    end
    if (aw_pend || w_pend) timeout_fail("aw_w");
  endtask

  task automatic wait_b(output resp_t resp, output logic [NRegs-1:0] pulse, output int lat);
    lat = 0;
    slv.b_ready = 1;
    while (!slv.b_valid && lat < 20) begin tick(); lat++; end
    if (!slv.b_valid) begin
      timeout_fail("b"); resp = 'x; pulse = 'x; slv.b_ready = 0;
      return;
    end
    resp = slv.b_resp; pulse = wr_pulse;
    tick();
    slv.b_ready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output resp_t r,
                         output int lat);
    int n = 0;
    slv.ar_addr = a; slv.ar_prot = 3'($urandom); slv.ar_valid = 1; slv.r_ready = 1;
    while (!slv.ar_ready && n < 20) begin tick(); n++; end
    tick();
    slv.ar_valid = 0;
    lat = 0;
    while (!slv.r_valid && lat < 20) begin tick(); lat++; end
    if (!slv.r_valid) begin
      timeout_fail("r"); d = 'x; r = 'x; slv.r_ready = 0;
      return;
    end
    d = slv.r_data; r = slv.r_resp;
    tick();
    slv.r_ready = 0;
  endtask

  task automatic hw_pulse(input int i, input logic [31:0] v);
    hw_load[i] = 1; hw_d[i] = v;
    tick();
    hw_load = '0;
    if (is_ro(i)) model[i] = v;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_cmp++;
    if ({slv.aw_ready, slv.w_ready, slv.ar_ready} !== 3'b111) begin
      n_bad++; $display("FAIL reset_ready: got %b want 111", {slv.aw_ready, slv.w_ready, slv.ar_ready});
    end
    n_cmp++;
    if ({slv.b_valid, slv.r_valid, wr_pulse} !== '0) begin
      n_bad++; $display("FAIL reset_valid: got b=%b r=%b pulse=%h want 0", slv.b_valid, slv.r_valid, wr_pulse);
    end
    n_cmp++;
    if ({slv.b_resp, slv.r_resp, slv.r_data} !== '0) begin
      n_bad++; $display("FAIL reset_resp: got b=%h r=%h d=%h want 0", slv.b_resp, slv.r_resp, slv.r_data);
    end
    for (int i = 0; i < NRegs; i++) begin
      n_cmp++;
      if (reg_q[i] !== model[i]) begin
        n_bad++; $display("FAIL reset_reg%0d: got %h want %h", i, reg_q[i], model[i]);
      end
    end
  endtask

  task automatic test_write_basic();
    resp_t resp; logic [NRegs-1:0] pulse; int lat;
    send_aw_w(32'h4, 32'hDEAD_BEEF, 4'hF);
    wait_b(resp, pulse, lat);
    model[1] = merge(model[1], 32'hDEAD_BEEF, 4'hF);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wr_latency: got %0d want 1", lat); end
    n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL wr_resp: got %b want 00", resp); end
    n_cmp++; if (pulse !== 16'h0002) begin n_bad++; $display("FAIL wr_pulse: got %h want 0002", pulse); end
    n_cmp++; if (wr_pulse !== '0) begin n_bad++; $display("FAIL wr_pulse_len: got %h want 0000", wr_pulse); end
    n_cmp++; if (slv.b_valid !== 1'b0) begin n_bad++; $display("FAIL wr_b_clear: got %b want 0", slv.b_valid); end
    n_cmp++; if (reg_q[1] !== model[1]) begin n_bad++; $display("FAIL wr_reg1: got %h want %h", reg_q[1], model[1]); end
  endtask

  task automatic test_w_before_aw();
    int n = 0; logic [31:0] exp;
    exp = merge(model[2], 32'h1122_3344, 4'b0101);
    slv.w_data = 32'h1122_3344; slv.w_strb = 4'b0101; slv.w_valid = 1;
    while (!slv.w_ready && n < 20) begin tick(); n++; end
    tick();
    slv.w_valid = 0;
    repeat (2) tick();  // AW presented three cycles after W
    n_cmp++;
    if (slv.aw_ready !== 1'b1 || slv.w_ready !== 1'b0) begin
      n_bad++; $display("FAIL wb_ready_pre: got aw=%b w=%b want aw=1 w=0", slv.aw_ready, slv.w_ready);
    end
    slv.aw_addr = 32'h8; slv.aw_valid = 1;
    tick();
    slv.aw_valid = 0;
    tick();
    n_cmp++;
    if (slv.b_valid !== 1'b1 || slv.b_resp !== 2'b00 || wr_pulse !== 16'h0004) begin
      n_bad++; $display("FAIL wb_b: got v=%b r=%b p=%h want v=1 r=00 p=0004", slv.b_valid, slv.b_resp, wr_pulse);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({slv.aw_ready, slv.w_ready, slv.b_valid, slv.b_resp, wr_pulse} !== {3'b001, 2'b00, 16'h0}) begin
        n_bad++; $display("FAIL wb_hold%0d: got aw=%b w=%b bv=%b br=%b p=%h want 0 0 1 00 0000",
                          k, slv.aw_ready, slv.w_ready, slv.b_valid, slv.b_resp, wr_pulse);
      end
    end
    slv.b_ready = 1;
    tick();
    slv.b_ready = 0;
    n_cmp++;
    if ({slv.b_valid, slv.aw_ready, slv.w_ready} !== 3'b011) begin
      n_bad++; $display("FAIL wb_release: got %b want 011", {slv.b_valid, slv.aw_ready, slv.w_ready});
    end
    model[2] = exp;
    n_cmp++;
    if (reg_q[2] !== 32'hAA22_AA44) begin
      n_bad++; $display("FAIL wb_reg2: got %h want aa22aa44", reg_q[2]);
    end
  endtask

  task automatic test_read_backpressure();
    int n = 0;
    slv.ar_addr = 32'h4; slv.ar_valid = 1; slv.r_ready = 0;
    while (!slv.ar_ready && n < 20) begin tick(); n++; end
    tick();
    slv.ar_valid = 0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (slv.r_valid !== 1'b1 || slv.r_data !== model[1] || slv.ar_ready !== 1'b0 || slv.r_resp !== 2'b00) begin
        n_bad++; $display("FAIL rd_hold%0d: got v=%b d=%h ar=%b r=%b want v=1 d=%h ar=0 r=00",
                          k, slv.r_valid, slv.r_data, slv.ar_ready, slv.r_resp, model[1]);
      end
      tick();
    end
    slv.r_ready = 1;
    tick();
    slv.r_ready = 0;
    n_cmp++;
    if (slv.r_valid !== 1'b0 || slv.ar_ready !== 1'b1) begin
      n_bad++; $display("FAIL rd_release: got v=%b ar=%b want v=0 ar=1", slv.r_valid, slv.ar_ready);
    end
  endtask

  task automatic test_decode_error();
    resp_t resp; logic [NRegs-1:0] pulse; int lat; logic [31:0] d;
    send_aw_w(32'h40, $urandom, 4'hF);
    wait_b(resp, pulse, lat);
    n_cmp++; if (resp !== 2'b11) begin n_bad++; $display("FAIL dec_wresp: got %b want 11", resp); end
    n_cmp++; if (pulse !== '0) begin n_bad++; $display("FAIL dec_pulse: got %h want 0000", pulse); end
    for (int i = 0; i < NRegs; i++) begin
      n_cmp++;
      if (reg_q[i] !== model[i]) begin
        n_bad++; $display("FAIL dec_reg%0d: got %h want %h", i, reg_q[i], model[i]);
      end
    end
    do_read(32'h40, d, resp, lat);
    n_cmp++;
    if (d !== 32'h0 || resp !== 2'b11) begin
      n_bad++; $display("FAIL dec_read: got d=%h r=%b want d=0 r=11", d, resp);
    end
  endtask

  task automatic test_read_only();
    resp_t resp; logic [NRegs-1:0] pulse; int lat; logic [31:0] d;
    send_aw_w(32'hC, 32'h5, 4'hF);
    wait_b(resp, pulse, lat);
    n_cmp++;
    if (resp !== 2'b10 || pulse !== '0 || reg_q[3] !== model[3]) begin
      n_bad++; $display("FAIL ro_write: got r=%b p=%h q=%h want r=10 p=0000 q=%h", resp, pulse, reg_q[3], model[3]);
    end
    hw_pulse(3, 32'h77);
    do_read(32'hC, d, resp, lat);
    n_cmp++;
    if (d !== 32'h77 || resp !== 2'b00) begin
      n_bad++; $display("FAIL ro_hwload: got d=%h r=%b want d=77 r=00", d, resp);
    end
    hw_pulse(1, 32'hCAFE_F00D);
    n_cmp++;
    if (reg_q[1] !== model[1]) begin
      n_bad++; $display("FAIL hw_ignored: got %h want %h", reg_q[1], model[1]);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] old_v, new_v;
    old_v = model[6];
    new_v = $urandom;
    send_aw_w(32'h18, new_v, 4'hF);
    slv.ar_addr = 32'h18; slv.ar_valid = 1;
    tick();  // AR handshake coincides with the write commit
    slv.ar_valid = 0;
    model[6] = new_v;
    n_cmp++;
    if (slv.r_valid !== 1'b1 || slv.r_data !== old_v || slv.b_valid !== 1'b1 || reg_q[6] !== new_v) begin
      n_bad++; $display("FAIL same_edge: got rv=%b rd=%h bv=%b q=%h want rv=1 rd=%h bv=1 q=%h",
                        slv.r_valid, slv.r_data, slv.b_valid, reg_q[6], old_v, new_v);
    end
    slv.r_ready = 1; slv.b_ready = 1;
    tick();
    slv.r_ready = 0; slv.b_ready = 0;
    n_cmp++;
    if (slv.r_valid !== 1'b0 || slv.b_valid !== 1'b0) begin
      n_bad++; $display("FAIL same_edge_done: got rv=%b bv=%b want 0 0", slv.r_valid, slv.b_valid);
    end
  endtask

  task automatic test_random();
    resp_t resp; logic [NRegs-1:0] pulse; int lat; logic [31:0] d, a, data; logic [3:0] s;
    int idx;
    for (int it = 0; it < 60; it++) begin
      idx = $urandom_range(0, 19);
      a = 32'(idx * 4 + $urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: begin
          data = $urandom; s = 4'($urandom);
          send_aw_w(a, data, s);
          wait_b(resp, pulse, lat);
          n_cmp++;
          if (resp !== exp_wresp(a) || lat !== 1 ||
              pulse !== ((exp_wresp(a) == 2'b00) ? (16'h1 << idx) : 16'h0)) begin
            n_bad++; $display("FAIL rnd_write%0d a=%h: got r=%b p=%h lat=%0d want r=%b lat=1",
                              it, a, resp, pulse, lat, exp_wresp(a));
          end
          if (exp_wresp(a) == 2'b00) model[idx] = merge(model[idx], data, s);
        end
        1: begin
          do_read(a, d, resp, lat);
          n_cmp++;
          if (idx < NRegs) begin
            if (d !== model[idx] || resp !== 2'b00 || lat !== 0) begin
              n_bad++; $display("FAIL rnd_read%0d a=%h: got d=%h r=%b lat=%0d want d=%h r=00 lat=0",
                                it, a, d, resp, lat, model[idx]);
            end
          end else if (d !== 32'h0 || resp !== 2'b11 || lat !== 0) begin
            n_bad++; $display("FAIL rnd_read%0d a=%h: got d=%h r=%b lat=%0d want d=0 r=11 lat=0",
                              it, a, d, resp, lat);
          end
        end
        default: begin
          idx = ($urandom_range(0, 1) == 1) ? 3 : $urandom_range(0, NRegs - 1);
          hw_pulse(idx, $urandom);
        end
      endcase
      if (idx < NRegs) begin
        n_cmp++;
        if (reg_q[idx] !== model[idx]) begin
          n_bad++; $display("FAIL rnd_reg%0d it=%0d: got %h want %h", idx, it, reg_q[idx], model[idx]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    resp_t resp; logic [NRegs-1:0] pulse; int lat; logic [31:0] d;
    send_aw_w(32'h14, 32'h0BAD_0BAD, 4'hF);
    tick();  // B now pending with b_ready low
    slv.ar_addr = 32'h8; slv.ar_valid = 1; slv.r_ready = 0;
    tick();
    slv.ar_valid = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    n_cmp++;
    if ({slv.b_valid, slv.r_valid, wr_pulse} !== '0 ||
        {slv.aw_ready, slv.w_ready, slv.ar_ready} !== 3'b111) begin
      n_bad++; $display("FAIL rst_mid_ctrl: got bv=%b rv=%b p=%h rdy=%b want 0 0 0000 111", slv.b_valid,
                        slv.r_valid, wr_pulse, {slv.aw_ready, slv.w_ready, slv.ar_ready});
    end
    for (int i = 0; i < NRegs; i++) begin
      n_cmp++;
      if (reg_q[i] !== model[i]) begin
        n_bad++; $display("FAIL rst_mid_reg%0d: got %h want %h", i, reg_q[i], model[i]);
      end
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    send_aw_w(32'h14, 32'h600D_600D, 4'hF);
    wait_b(resp, pulse, lat);
    model[5] = 32'h600D_600D;
    n_cmp++;
    if (resp !== 2'b00 || pulse !== 16'h0020) begin
      n_bad++; $display("FAIL rst_after_wr: got r=%b p=%h want r=00 p=0020", resp, pulse);
    end
    do_read(32'h14, d, resp, lat);
    n_cmp++;
    if (d !== model[5] || resp !== 2'b00) begin
      n_bad++; $display("FAIL rst_after_rd: got d=%h r=%b want d=%h r=00", d, resp, model[5]);
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation still running at 500us, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    tick();
    test_reset();
    test_write_basic();
    test_w_before_aw();
    test_read_backpressure();
    test_decode_error();
    test_read_only();
    test_same_edge();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
